cart_header_decoder: RTL and testbench
======================================

// Module: cart_header_decoder
// PURPOSE
//  Snoops the 16-bit ROM download stream, captures the cartridge header (0x0143, 0x0147-0x0149,
//  0x0134-0x014D) and the image size, then decodes mapper selects, rom/ram masks and flags.
//  Sits directly upstream of the mappers block, driving its mbc*/huc*/mask/type/isGBC_game inputs.
//  Outputs change only in one registered decode step after download ends; stable otherwise.
// PARAMETERS
//  AW  25  download byte-address width
// PORTS
//  clk_sys        in   1   system clock
//  reset_n        in   1   synchronous, active-low reset
//  dl_active      in   1   ROM download in progress
//  dl_wr          in   1   word write strobe, valid only while dl_active=1
//  dl_addr        in   AW  byte address, always even
//  dl_data        in   16  [7:0]=byte at dl_addr, [15:8]=byte at dl_addr+1
//  hdr_valid      out  1   decoded outputs valid for last completed download
//  hdr_chk_ok     out  1   computed header checksum == byte 0x014D
//  cart_mbc_type  out  8   raw byte 0x0147
//  isGBC_game     out  1   byte 0x0143 bit 7
//  mbc1,mbc2,mbc3,mbc30,mbc5,mbc6,mbc7,mmm01,huc1,huc3,gb_camera,tama  out 1 each  mapper selects
//  has_ram        out  1   cart carries RAM
//  rom_mask       out  9   16KB ROM bank mask
//  ram_mask       out  4   8KB RAM bank mask
//  img_size       out  AW  bytes loaded = highest dl_addr written + 2
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state IDLE; every output 0; capture regs 0; checksum acc 0.
//  FSM: IDLE -> LOAD on dl_active rising edge (prev 0, now 1); clears hdr_valid, acc, img_size.
//   LOAD: on dl_wr capture: 0x0142 hi->cgb; 0x0146 hi->type; 0x0148 lo->romsz, hi->ramsz;
//   0x0134..0x014A: acc = acc - lo - hi - 2; 0x014C: acc = acc - lo - 1, hi->chk (8-bit wrap).
//   img_size <= max(img_size, dl_addr+2) on every dl_wr.
//   LOAD -> DECODE when dl_active sampled 0. DECODE -> DONE next cycle, registering all outputs;
//   hdr_valid=1 in DONE. Latency: dl_active low at edge N -> outputs/hdr_valid valid after edge N+2.
//   DONE -> LOAD on next dl_active rising edge. dl_active already high out of reset: no LOAD until
//   it drops and rises again. dl_wr with dl_active=0 ignored. Reset mid-LOAD aborts, all outputs 0.
//  Type decode (exactly one select or none): 01-03 mbc1; 05-06 mbc2; 0B-0D mmm01; 0F-13 mbc3;
//   19-1E mbc5; 20 mbc6; 22 mbc7; FC gb_camera; FD tama; FE huc3; FF huc1; other -> all 0.
//  mbc30 = mbc3 & (ramsz==05 | romsz==07).
//  has_ram = type in {02,03,05,06,08,09,0C,0D,10,12,13,1A,1B,1D,1E,22,FC,FD,FE,FF}.
//  rom_mask: romsz 00-08 -> (2<<romsz)-1; 52/53/54 -> 9'h07F; other -> 9'h1FF.
//  ram_mask: ramsz 00,01,02 -> 0; 03 -> 3; 04 -> 15; 05 -> 7; other -> 15.
//  hdr_chk_ok = (acc == chk) registered in DECODE. Download shorter than 0x014E: fields keep 0.
// TESTING
//  Tetris-like: type 00, romsz 00, ramsz 00, valid checksum -> all selects 0, rom_mask 001, ram_mask 0, chk_ok 1, img_size 0x8000.
//  type 1B, romsz 06, ramsz 03, cgb C0 -> mbc5=1, has_ram=1, rom_mask 07F, ram_mask 3, isGBC_game=1.
//  type 13, ramsz 05 -> mbc3=1, mbc30=1, ram_mask 7; type 0x55 -> no select, has_ram 0.
//  Corrupt 0x014D by +1 -> hdr_chk_ok=0, other outputs unchanged; romsz 52 -> rom_mask 07F.
//  dl_active falls at edge N -> hdr_valid 0 at N+1, 1 at N+2; new download clears hdr_valid on rise.
//  reset_n=0 mid-LOAD while dl_active stays 1 -> outputs 0, stays IDLE, hdr_valid never sets.

Source files
------------

// File: rtl/cart_header_decoder_if.sv
// ROM download bus snooped by the cartridge header decoder.
interface cart_header_decoder_if #(
  parameter int AW = 25
);
  logic          dl_active;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [15:0]   dl_data;

  modport master (output dl_active, dl_wr, dl_addr, dl_data);
  modport slave  (input  dl_active, dl_wr, dl_addr, dl_data);
endinterface

// File: rtl/cart_header_decoder.sv
// Captures the cartridge header from the ROM download stream and decodes mapper
// selects, bank masks and flags in a single registered step after the download ends.
module cart_header_decoder #(
  parameter int AW = 25
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  cart_header_decoder_if.slave dl,
  output logic                 hdr_valid,
  output logic                 hdr_chk_ok,
  output logic [7:0]           cart_mbc_type,
  output logic                 isGBC_game,
  output logic                 mbc1,
  output logic                 mbc2,
  output logic                 mbc3,
  output logic                 mbc30,
  output logic                 mbc5,
  output logic                 mbc6,
  output logic                 mbc7,
  output logic                 mmm01,
  output logic                 huc1,
  output logic                 huc3,
  output logic                 gb_camera,
  output logic                 tama,
  output logic                 has_ram,
  output logic [8:0]           rom_mask,
  output logic [3:0]           ram_mask,
  output logic [AW-1:0]        img_size
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          act_prev_q, act_prev_d;
  logic [7:0]    cgb_q, cgb_d, type_q, type_d, romsz_q, romsz_d;
  logic [7:0]    ramsz_q, ramsz_d, chk_q, chk_d, acc_q, acc_d;
  logic [AW-1:0] img_acc_q, img_acc_d;

  logic          valid_q, valid_d, chk_ok_q, chk_ok_d;
  logic [7:0]    mbc_type_q, mbc_type_d;
  logic          gbc_q, gbc_d, has_ram_q, has_ram_d;
  logic [11:0]   sel_q, sel_d;
  logic [8:0]    rom_mask_q, rom_mask_d;
  logic [3:0]    ram_mask_q, ram_mask_d;
  logic [AW-1:0] img_size_q, img_size_d;

  logic [11:0]   sel_dec;
  logic          has_ram_dec;
  logic [8:0]    rom_mask_dec;
  logic [3:0]    ram_mask_dec;
  logic [7:0]    lo, hi;
  logic [AW-1:0] addr_p2;

  // sel bit order: mbc1 mbc2 mbc3 mbc30 mbc5 mbc6 mbc7 mmm01 huc1 huc3 gb_camera tama
  always_comb begin
    sel_dec = '0;
    if (type_q inside {[8'h01:8'h03]}) sel_dec[11] = 1'b1;
    if (type_q inside {[8'h05:8'h06]}) sel_dec[10] = 1'b1;
    if (type_q inside {[8'h0F:8'h13]}) sel_dec[9]  = 1'b1;
    sel_dec[8] = sel_dec[9] & ((ramsz_q == 8'h05) | (romsz_q == 8'h07));
    if (type_q inside {[8'h19:8'h1E]}) sel_dec[7]  = 1'b1;
    if (type_q == 8'h20)               sel_dec[6]  = 1'b1;
    if (type_q == 8'h22)               sel_dec[5]  = 1'b1;
    if (type_q inside {[8'h0B:8'h0D]}) sel_dec[4]  = 1'b1;
    if (type_q == 8'hFF)               sel_dec[3]  = 1'b1;
    if (type_q == 8'hFE)               sel_dec[2]  = 1'b1;
    if (type_q == 8'hFC)               sel_dec[1]  = 1'b1;
    if (type_q == 8'hFD)               sel_dec[0]  = 1'b1;

    has_ram_dec = type_q inside {8'h02, 8'h03, 8'h05, 8'h06, 8'h08, 8'h09, 8'h0C, 8'h0D,
                                 8'h10, 8'h12, 8'h13, 8'h1A, 8'h1B, 8'h1D, 8'h1E, 8'h22,
                                 8'hFC, 8'hFD, 8'hFE, 8'hFF};

    if (romsz_q <= 8'h08)
      rom_mask_dec = 9'((10'd2 << romsz_q[3:0]) - 10'd1);
    else if (romsz_q inside {[8'h52:8'h54]})
      rom_mask_dec = 9'h07F;
    else
      rom_mask_dec = 9'h1FF;

    case (ramsz_q)
      8'h00, 8'h01, 8'h02: ram_mask_dec = 4'd0;
      8'h03:               ram_mask_dec = 4'd3;
      8'h05:               ram_mask_dec = 4'd7;
      default:             ram_mask_dec = 4'd15;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    act_prev_d = dl.dl_active;
    cgb_d      = cgb_q;
    type_d     = type_q;
    romsz_d    = romsz_q;
    ramsz_d    = ramsz_q;
    chk_d      = chk_q;
    acc_d      = acc_q;
    img_acc_d  = img_acc_q;
    valid_d    = valid_q;
    chk_ok_d   = chk_ok_q;
    mbc_type_d = mbc_type_q;
    gbc_d      = gbc_q;
    sel_d      = sel_q;
    has_ram_d  = has_ram_q;
    rom_mask_d = rom_mask_q;
    ram_mask_d = ram_mask_q;
    img_size_d = img_size_q;
    lo         = dl.dl_data[7:0];
    hi         = dl.dl_data[15:8];
    addr_p2    = dl.dl_addr + AW'(2);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (dl.dl_active && !act_prev_q) begin
          state_d   = ST_LOAD;
          valid_d   = 1'b0;
          acc_d     = '0;
          img_acc_d = '0;
          cgb_d     = '0;
          type_d    = '0;
          romsz_d   = '0;
          ramsz_d   = '0;
          chk_d     = '0;
        end
      end
      ST_LOAD: begin
        if (!dl.dl_active) begin
          state_d = ST_DECODE;
        end else if (dl.dl_wr) begin
          if (dl.dl_addr == AW'('h142)) cgb_d  = hi;
          if (dl.dl_addr == AW'('h146)) type_d = hi;
          if (dl.dl_addr == AW'('h148)) begin
            romsz_d = lo;
            ramsz_d = hi;
          end
          // Header checksum walks bytes 0x134..0x14C as x = x - byte - 1, two per word.
          if (dl.dl_addr >= AW'('h134) && dl.dl_addr <= AW'('h14A))
            acc_d = acc_q - lo - hi - 8'd2;
          if (dl.dl_addr == AW'('h14C)) begin
            acc_d = acc_q - lo - 8'd1;
            chk_d = hi;
          end
          if (addr_p2 > img_acc_q) img_acc_d = addr_p2;
        end
      end
      ST_DECODE: begin
        state_d    = ST_DONE;
        valid_d    = 1'b1;
        chk_ok_d   = (acc_q == chk_q);
        mbc_type_d = type_q;
        gbc_d      = cgb_q[7];
        sel_d      = sel_dec;
        has_ram_d  = has_ram_dec;
        rom_mask_d = rom_mask_dec;
        ram_mask_d = ram_mask_dec;
        img_size_d = img_acc_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // act_prev resets high so a download already in progress at reset release is not entered.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      act_prev_q <= 1'b1;
      cgb_q      <= '0;
      type_q     <= '0;
      romsz_q    <= '0;
      ramsz_q    <= '0;
      chk_q      <= '0;
      acc_q      <= '0;
      img_acc_q  <= '0;
      valid_q    <= 1'b0;
      chk_ok_q   <= 1'b0;
      mbc_type_q <= '0;
      gbc_q      <= 1'b0;
      sel_q      <= '0;
      has_ram_q  <= 1'b0;
      rom_mask_q <= '0;
      ram_mask_q <= '0;
      img_size_q <= '0;
    end else begin
      state_q    <= state_d;
      act_prev_q <= act_prev_d;
      cgb_q      <= cgb_d;
      type_q     <= type_d;
      romsz_q    <= romsz_d;
      ramsz_q    <= ramsz_d;
      chk_q      <= chk_d;
      acc_q      <= acc_d;
      img_acc_q  <= img_acc_d;
      valid_q    <= valid_d;
      chk_ok_q   <= chk_ok_d;
      mbc_type_q <= mbc_type_d;
      gbc_q      <= gbc_d;
      sel_q      <= sel_d;
      has_ram_q  <= has_ram_d;
      rom_mask_q <= rom_mask_d;
      ram_mask_q <= ram_mask_d;
      img_size_q <= img_size_d;
    end
  end

  assign hdr_valid     = valid_q;
  assign hdr_chk_ok    = chk_ok_q;
  assign cart_mbc_type = mbc_type_q;
  assign isGBC_game    = gbc_q;
  assign {mbc1, mbc2, mbc3, mbc30, mbc5, mbc6, mbc7, mmm01, huc1, huc3, gb_camera, tama} = sel_q;
  assign has_ram       = has_ram_q;
  assign rom_mask      = rom_mask_q;
  assign ram_mask      = ram_mask_q;
  assign img_size      = img_size_q;

endmodule

// File: tb/tb_cart_header_decoder.sv
// Directed and randomized header downloads checked against a byte-level reference model.
module tb_cart_header_decoder;
  localparam int AW = 25;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  cart_header_decoder_if #(.AW(AW)) dl_if ();

  logic          hdr_valid, hdr_chk_ok, isGBC_game, has_ram;
  logic [7:0]    cart_mbc_type;
  logic          mbc1, mbc2, mbc3, mbc30, mbc5, mbc6, mbc7, mmm01, huc1, huc3, gb_camera, tama;
  logic [8:0]    rom_mask;
  logic [3:0]    ram_mask;
  logic [AW-1:0] img_size;

  cart_header_decoder #(.AW(AW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl(dl_if),
    .hdr_valid(hdr_valid), .hdr_chk_ok(hdr_chk_ok), .cart_mbc_type(cart_mbc_type),
    .isGBC_game(isGBC_game), .mbc1(mbc1), .mbc2(mbc2), .mbc3(mbc3), .mbc30(mbc30),
    .mbc5(mbc5), .mbc6(mbc6), .mbc7(mbc7), .mmm01(mmm01), .huc1(huc1), .huc3(huc3),
    .gb_camera(gb_camera), .tama(tama), .has_ram(has_ram), .rom_mask(rom_mask),
    .ram_mask(ram_mask), .img_size(img_size)
  );

  int unsigned checks = 0;
  int unsigned passed = 0;

  logic [7:0]  mem [0:'h14F];
  logic [7:0]  e_type;
  logic        e_cgb, e_chk_ok, e_has_ram;
  logic [11:0] e_sel;
  logic [8:0]  e_rom;
  logic [3:0]  e_ram;
  int          e_img;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] hb(input int x, input int len);
    return (((x & ~1) + 2) <= len) ? mem[x] : 8'h00;
  endfunction

  task automatic model_clear();
    e_type = '0; e_cgb = 0; e_chk_ok = 0; e_has_ram = 0;
    e_sel = '0; e_rom = '0; e_ram = '0; e_img = 0;
  endtask

  // Reference: bits are mbc1 mbc2 mbc3 mbc30 mbc5 mbc6 mbc7 mmm01 huc1 huc3 gb_camera tama
  task automatic model(input int len);
    logic [7:0] t, romsz, ramsz, b;
    int acc;
    t = hb('h147, len); romsz = hb('h148, len); ramsz = hb('h149, len); b = hb('h143, len);
    e_type = t;
    e_cgb  = b[7];
    acc = 0;
    for (int x = 'h134; x <= 'h14C; x++)
      if (((x & ~1) + 2) <= len) acc = acc - int'(mem[x]) - 1;
    e_chk_ok = (acc[7:0] == hb('h14D, len));
    e_sel = '0;
    if (t >= 8'h01 && t <= 8'h03) e_sel[11] = 1;
    if (t == 8'h05 || t == 8'h06) e_sel[10] = 1;
    if (t >= 8'h0F && t <= 8'h13) e_sel[9] = 1;
    if (e_sel[9] && (ramsz == 8'h05 || romsz == 8'h07)) e_sel[8] = 1;
    if (t >= 8'h19 && t <= 8'h1E) e_sel[7] = 1;
    if (t == 8'h20) e_sel[6] = 1;
    if (t == 8'h22) e_sel[5] = 1;
    if (t >= 8'h0B && t <= 8'h0D) e_sel[4] = 1;
    if (t == 8'hFF) e_sel[3] = 1;
    if (t == 8'hFE) e_sel[2] = 1;
    if (t == 8'hFC) e_sel[1] = 1;
    if (t == 8'hFD) e_sel[0] = 1;
    e_has_ram = t inside {8'h02, 8'h03, 8'h05, 8'h06, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h10,
                          8'h12, 8'h13, 8'h1A, 8'h1B, 8'h1D, 8'h1E, 8'h22, 8'hFC, 8'hFD,
                          8'hFE, 8'hFF};
    if (romsz <= 8) e_rom = 9'((1 << (int'(romsz) + 1)) - 1);
    else if (romsz >= 8'h52 && romsz <= 8'h54) e_rom = 9'd127;
    else e_rom = 9'd511;
    if (ramsz <= 2) e_ram = 0;
    else if (ramsz == 3) e_ram = 3;
    else if (ramsz == 4) e_ram = 15;
    else if (ramsz == 5) e_ram = 7;
    else e_ram = 15;
    e_img = len;
  endtask

  task automatic fill_header(input logic [7:0] t, input logic [7:0] romsz,
                             input logic [7:0] ramsz, input logic [7:0] cgb, input int corrupt);
    int acc;
    for (int i = 'h100; i <= 'h14F; i++) mem[i] = 8'($urandom);
    mem['h143] = cgb; mem['h147] = t; mem['h148] = romsz; mem['h149] = ramsz;
    acc = 0;
    for (int x = 'h134; x <= 'h14C; x++) acc = acc - int'(mem[x]) - 1;
    mem['h14D] = acc[7:0] + 8'(corrupt);
  endtask

  task automatic check_outputs(input string p, input logic v);
    check({p, "_valid"}, hdr_valid, v);
    check({p, "_chk_ok"}, hdr_chk_ok, e_chk_ok);
    check({p, "_type"}, cart_mbc_type, e_type);
    check({p, "_cgb"}, isGBC_game, e_cgb);
    check({p, "_sel"}, {mbc1, mbc2, mbc3, mbc30, mbc5, mbc6, mbc7, mmm01, huc1, huc3,
                        gb_camera, tama}, e_sel);
    check({p, "_has_ram"}, has_ram, e_has_ram);
    check({p, "_rom_mask"}, rom_mask, e_rom);
    check({p, "_ram_mask"}, ram_mask, e_ram);
    check({p, "_img_size"}, img_size, AW'(e_img));
  endtask

  // Writes header words 0x100.. below len, then the last word of the image, then drops dl_active.
  task automatic download(input string p, input int len);
    @(negedge clk_sys);
    dl_if.dl_active = 1; dl_if.dl_wr = 0;
    @(negedge clk_sys);
    check({p, "_rise_valid"}, hdr_valid, 1'b0);
    for (int a = 'h100; a <= 'h14E && a + 2 <= len; a += 2) begin
      dl_if.dl_wr = 1; dl_if.dl_addr = AW'(a); dl_if.dl_data = {mem[a+1], mem[a]};
      @(negedge clk_sys);
      if ($urandom_range(0, 3) == 0) begin
        dl_if.dl_wr = 0;
        @(negedge clk_sys);
      end
    end
    if (len > 'h150) begin
      dl_if.dl_wr = 1; dl_if.dl_addr = AW'(len - 2); dl_if.dl_data = 16'($urandom);
      @(negedge clk_sys);
    end
    dl_if.dl_active = 0; dl_if.dl_wr = 1;
    dl_if.dl_addr = AW'('h14C); dl_if.dl_data = 16'($urandom);
    @(negedge clk_sys);
    dl_if.dl_wr = 0;
    check_outputs({p, "_n1"}, 1'b0);
    @(negedge clk_sys);
    model(len);
    check_outputs({p, "_n2"}, 1'b1);
  endtask

  initial begin
    logic [7:0] pool [0:15];
    logic [7:0] t, rs, ms;
    int r, len;
    pool = '{8'h00, 8'h01, 8'h03, 8'h05, 8'h06, 8'h0B, 8'h0D, 8'h0F, 8'h13, 8'h19,
             8'h1E, 8'h20, 8'h22, 8'hFC, 8'hFD, 8'hFE};
    dl_if.dl_active = 0; dl_if.dl_wr = 0; dl_if.dl_addr = '0; dl_if.dl_data = '0;
    model_clear();
    repeat (3) @(negedge clk_sys);
    reset_n = 1;
    @(negedge clk_sys);
    check_outputs("reset", 1'b0);

    fill_header(8'h00, 8'h00, 8'h00, 8'h00, 0);
    download("tetris", 'h8000);
    check("tetris_rom_const", rom_mask, 9'h001);
    check("tetris_chk_const", hdr_chk_ok, 1'b1);

    fill_header(8'h1B, 8'h06, 8'h03, 8'hC0, 0);
    download("mbc5", 'h20000);
    check("mbc5_const", {mbc5, has_ram, rom_mask, ram_mask, isGBC_game}, {1'b1, 1'b1, 9'h07F, 4'd3, 1'b1});

    fill_header(8'h1B, 8'h06, 8'h03, 8'hC0, 1);
    download("corrupt", 'h20000);
    check("corrupt_chk_const", hdr_chk_ok, 1'b0);

    fill_header(8'h13, 8'h02, 8'h05, 8'h00, 0);
    download("mbc30", 'h10000);
    check("mbc30_const", {mbc3, mbc30, ram_mask}, {1'b1, 1'b1, 4'd7});

    fill_header(8'h55, 8'h52, 8'h01, 8'h80, 0);
    download("other", 'h4000);
    check("other_const", {has_ram, rom_mask}, {1'b0, 9'h07F});

    fill_header(8'h03, 8'h04, 8'h03, 8'h80, 0);
    download("short", 'h140);

    for (int n = 0; n < 12; n++) begin
      t = (n % 3 == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
      r = $urandom_range(0, 14);
      rs = (r <= 10) ? 8'(r) : (r <= 13) ? 8'('h52 + r - 11) : 8'($urandom);
      ms = 8'($urandom_range(0, 7));
      len = 2 * $urandom_range('h80, 'h4000);
      fill_header(t, rs, ms, 8'($urandom), $urandom_range(0, 3) == 0 ? 1 : 0);
      download($sformatf("rand%0d", n), len);
    end

    // Reset while a download is in progress; dl_active held high across reset release.
    fill_header(8'h1B, 8'h05, 8'h04, 8'hC0, 0);
    @(negedge clk_sys);
    dl_if.dl_active = 1;
    for (int a = 'h140; a <= 'h14E; a += 2) begin
      @(negedge clk_sys);
      dl_if.dl_wr = 1; dl_if.dl_addr = AW'(a); dl_if.dl_data = {mem[a+1], mem[a]};
      if (a == 'h146) reset_n = 0;
      if (a == 'h148) reset_n = 1;
    end
    @(negedge clk_sys);
    dl_if.dl_wr = 0;
    model_clear();
    check_outputs("rst_mid", 1'b0);
    dl_if.dl_active = 0;
    repeat (3) @(negedge clk_sys);
    check_outputs("rst_idle", 1'b0);

    fill_header(8'hFF, 8'h08, 8'h09, 8'h00, 0);
    download("after_rst", 'h40000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
